// File: rtl/gecko_pkg.sv
// -----------------------------------------------------------------------------
// gecko_pkg
// Shared types and constants for the gecko keystream XOR datapath.
//   fetch_state_e    : keystream fetch FSM states (IDLE, ACK)
//   KS_DEPTH_DEFAULT : default keystream FIFO depth in bytes
//   byte_t           : one data/keystream byte
// -----------------------------------------------------------------------------
package gecko_pkg;

  localparam int KS_DEPTH_DEFAULT = 2;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDLE = 1'b0,  // waiting for gecko to offer a byte
    ACK  = 1'b1   // byte captured, ks_next held until gecko drops ready
  } fetch_state_e;

endpackage

// File: rtl/gecko_xor_if.sv
// -----------------------------------------------------------------------------
// gecko_xor_if
// Bundles the three handshakes around gecko_xor.
//   ks_ready/ks_data/ks_next     : keystream byte handshake with gecko
//   in_valid/in_ready/in_data    : ciphertext byte stream into the block
//   out_valid/out_ready/out_data : plaintext byte stream out of the block
// Modports: slave = the gecko_xor view, master = the surrounding environment.
// -----------------------------------------------------------------------------
interface gecko_xor_if;
  import gecko_pkg::*;

  logic  ks_ready;
  byte_t ks_data;
  logic  ks_next;
  logic  in_valid;
  logic  in_ready;
  byte_t in_data;
  logic  out_valid;
  logic  out_ready;
  byte_t out_data;

  modport slave (
    input  ks_ready, ks_data, in_valid, in_data, out_ready,
    output ks_next, in_ready, out_valid, out_data
  );

  modport master (
    output ks_ready, ks_data, in_valid, in_data, out_ready,
    input  ks_next, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/gecko_ks_fifo.sv
// -----------------------------------------------------------------------------
// gecko_ks_fifo
// Synchronous FIFO buffering prefetched keystream bytes.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write a byte (ignored when full unless a pop happens too)
//   pop        : drop the head byte (ignored when empty)
//   head       : current oldest byte
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module gecko_ks_fifo
  import gecko_pkg::*;
#(
  parameter int DEPTH = KS_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  byte_t                  wdata,
  input  logic                   pop,
  output byte_t                  head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int                AW         = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_COUNT = (AW+1)'(DEPTH);

  byte_t         mem_q [DEPTH];
  byte_t         mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the push overwrites
  // (wr_ptr == rd_ptr), and the popped head is consumed this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; resetting the pointers and count already
  // makes the contents unreachable, and unreset storage maps to plain RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/gecko_xor.sv
// -----------------------------------------------------------------------------
// gecko_xor
// Keystream XOR datapath behind a gecko keystream generator. Prefetches
// keystream bytes into gecko_ks_fifo and XORs every accepted input byte with
// the oldest buffered keystream byte (decrypt and encrypt are the same op).
//   clk, rst_n : clock, asynchronous active-low reset shared with gecko
//   bus        : gecko_xor_if.slave (keystream, input and output handshakes)
//   bytes      : 32-bit count of output transfers, wraps; only present when
//                GECKO_XOR_COUNT_EN is defined
// Parameter KS_DEPTH: keystream FIFO depth, power of two, 2..16.
// -----------------------------------------------------------------------------
module gecko_xor
  import gecko_pkg::*;
#(
  parameter int KS_DEPTH = KS_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  gecko_xor_if.slave  bus
`ifdef GECKO_XOR_COUNT_EN
  ,
  output logic [31:0] bytes
`endif
);

  localparam int CW = $clog2(KS_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic          out_valid_q, out_valid_d;
  byte_t         out_data_q, out_data_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  byte_t         fifo_head;
  logic [CW-1:0] fifo_count;
  logic          in_ready, xfer;

  gecko_ks_fifo #(.DEPTH(KS_DEPTH)) u_ks_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (bus.ks_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Datapath: in_ready depends only on registered state and out_ready,
  // never on in_valid.
  always_comb begin
    in_ready    = (fifo_count != '0) && (!out_valid_q || bus.out_ready);
    xfer        = bus.in_valid && in_ready;
    fifo_pop    = xfer && !fifo_empty;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_data_d  = bus.in_data ^ fifo_head;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Fetch FSM: capture one byte per gecko ready window. ACK lasts until
  // gecko drops ready, which only happens on its own clock-enable edge.
  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ks_ready && (!fifo_full || fifo_pop)) begin
          fifo_push = 1'b1;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (!bus.ks_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // ks_next is high exactly while in ACK: it rises the cycle after capture
  // and falls the cycle after ready is sampled low.
  assign bus.ks_next   = (state_q == ACK);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef GECKO_XOR_COUNT_EN
  logic [31:0] bytes_q, bytes_d;

  always_comb begin
    bytes_d = bytes_q;
    if (out_valid_q && bus.out_ready) begin
      bytes_d = bytes_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q <= '0;
    end else begin
      bytes_q <= bytes_d;
    end
  end

  assign bytes = bytes_q;
`endif

endmodule

// File: tb/tb_gecko_xor.sv
// -----------------------------------------------------------------------------
// tb_gecko_xor
// Self-checking bench for gecko_xor. A behavioural gecko model offers bytes
// from ks_mem in order; the reference is "output k = input k XOR keystream
// byte k", kept as a queue of expected bytes. Buffered keystream is tracked
// as (bytes fetched) - (bytes consumed); a fetch is one rising ks_next.
// -----------------------------------------------------------------------------
module tb_gecko_xor;
  import gecko_pkg::*;

  localparam int KS_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gecko_xor_if bus ();

`ifdef GECKO_XOR_COUNT_EN
  logic [31:0] bytes;
`endif

  gecko_xor #(.KS_DEPTH(KS_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef GECKO_XOR_COUNT_EN
    ,
    .bytes (bytes)
`endif
  );

  // ---------------- gecko model ----------------
  byte_t ks_mem [256];
  int    m_idx;
  int    hold_cfg  = 1;
  bit    hold_rand = 1'b0;
  int    hold_cnt;
  int    cur_hold  = 1;

  // Offers ks_mem[m_idx]; after ks_next is seen for cur_hold cycles drops
  // ready and advances; raises ready again once ks_next is low.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.ks_ready = 1'b0;
      bus.ks_data  = 8'h00;
      m_idx        = 0;
      hold_cnt     = 0;
    end else if (bus.ks_ready) begin
      if (bus.ks_next) begin
        hold_cnt++;
        if (hold_cnt >= cur_hold) begin
          bus.ks_ready = 1'b0;
          bus.ks_data  = byte_t'($urandom);
          m_idx++;
          hold_cnt     = 0;
        end
      end
    end else if (!bus.ks_next) begin
      bus.ks_ready = 1'b1;
      bus.ks_data  = ks_mem[m_idx & 255];
      cur_hold     = hold_rand ? int'($urandom_range(1, 3)) : hold_cfg;
    end
  end

  // ---------------- scoreboard state ----------------
  int    n_checks = 0;
  int    n_errors = 0;
  int    fetched, consumed, out_total;
  byte_t exp_q[$];
  byte_t out_log[$];
  bit    acc_prev, nxt_chk_en, nxt_exp, prev_next, ov_prev, or_prev;
  byte_t od_prev, last_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    fetched    = 0;
    consumed   = 0;
    out_total  = 0;
    exp_q.delete();
    out_log.delete();
    acc_prev   = 1'b0;
    nxt_chk_en = 1'b0;
    prev_next  = 1'b0;
    ov_prev    = 1'b0;
    or_prev    = 1'b0;
    od_prev    = 8'h00;
  endtask

  task automatic fill_ks(input bit zero);
    foreach (ks_mem[i]) ks_mem[i] = zero ? 8'h00 : byte_t'($urandom);
  endtask

  // One clock: drive inputs on the falling edge, check 1 time unit later.
  task automatic tick(input bit v, input byte_t d, input bit r);
    byte_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    if (nxt_chk_en) check("ks_next_ack", bus.ks_next, nxt_exp);
    if (bus.ks_next && !prev_next) fetched++;
    prev_next  = bus.ks_next;
    nxt_chk_en = bus.ks_next;
    nxt_exp    = bus.ks_ready;
    if (acc_prev) begin
      check("lat_valid", bus.out_valid, 1);
      check("lat_data", bus.out_data, last_exp);
    end else if (ov_prev && !or_prev) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, od_prev);
    end
    check("fifo_bound", (fetched - consumed) <= KS_DEPTH, 1);
    check("in_ready", bus.in_ready, (fetched != consumed) && (!bus.out_valid || bus.out_ready));
`ifdef GECKO_XOR_COUNT_EN
    check("bytes_run", bytes, out_total);
`endif
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_spurious", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e);
        out_log.push_back(bus.out_data);
      end
      out_total++;
    end
    acc_prev = v && bus.in_ready;
    if (acc_prev) begin
      last_exp = d ^ ks_mem[consumed & 255];
      exp_q.push_back(last_exp);
      consumed++;
    end
    ov_prev = bus.out_valid;
    or_prev = r;
    od_prev = bus.out_data;
  endtask

  task automatic send(input byte_t d, input bit r);
    int n = 0;
    do begin
      tick(1'b1, d, r);
      n++;
    end while (!acc_prev && n < 40);
    if (!acc_prev) check("send_timeout", acc_prev, 1);
  endtask

  // Asserts reset mid-cycle; out_ready=1 so in_ready exposes FIFO occupancy.
  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    check("rst_ks_next", bus.ks_next, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 8'h00);
`ifdef GECKO_XOR_COUNT_EN
    check("rst_bytes", bytes, 0);
`endif
    repeat (2) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    clear_model();

    // Basic decode: keystream A5, 3C; in FF, 00 -> 5A, 3C
    fill_ks(1'b0);
    ks_mem[0] = 8'hA5;
    ks_mem[1] = 8'h3C;
    hold_cfg  = 1;
    do_reset();
    send(8'hFF, 1'b1);
    send(8'h00, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    check("t1_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("t1_out0", out_log[0], 8'h5A);
      check("t1_out1", out_log[1], 8'h3C);
    end

    // Long ready window, then full FIFO ignores ready
    fill_ks(1'b0);
    hold_cfg = 3;
    do_reset();
    repeat (25) tick(1'b0, 8'h00, 1'b1);
    check("t2_buffered", fetched, 2);
    check("t2_gecko_idx", m_idx, 2);
    check("t2_ks_next_full", bus.ks_next, 0);

    // Output stall: one byte taken, then 5 cycles of out_ready=0
    tick(1'b1, 8'h11, 1'b0);
    check("t4_first_acc", acc_prev, 1);
    repeat (5) tick(1'b1, 8'h22, 1'b0);
    check("t4_no_pop", consumed, 1);
    tick(1'b1, 8'h22, 1'b1);
    check("t4_resume0", acc_prev, 1);
    tick(1'b1, 8'h33, 1'b1);
    check("t4_resume1", acc_prev, 1);
    repeat (12) tick(1'b0, 8'h00, 1'b1);
    check("t4_drained", exp_q.size(), 0);

    // All-zero keystream passes data through
    fill_ks(1'b1);
    hold_cfg = 1;
    do_reset();
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    check("t5_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check("t5_out0", out_log[0], 8'h12);
      check("t5_out1", out_log[1], 8'h34);
    end
`ifdef GECKO_XOR_COUNT_EN
    check("t5_bytes", bytes, 2);
`endif

    // Reset while in ACK with one byte buffered
    fill_ks(1'b0);
    ks_mem[1] = ks_mem[0] ^ 8'h81;
    hold_cfg  = 8;
    do_reset();
    for (int i = 0; i < 30 && !bus.ks_next; i++) tick(1'b0, 8'h00, 1'b1);
    check("t6_in_ack", bus.ks_next, 1);
    check("t6_buffered", fetched, 1);
    hold_cfg = 1;
    do_reset();
    send(8'h5C, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    check("t6_count", out_log.size(), 1);
    if (out_log.size() == 1) begin
      check("t6_first_ks", out_log[0], 8'h5C ^ ks_mem[0]);
    end

    // Randomised traffic with random gecko ready windows
    fill_ks(1'b0);
    hold_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), byte_t'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (10) tick(1'b0, 8'h00, 1'b1);
    check("t7_drained", exp_q.size(), 0);
    check("t7_progress", consumed > 40, 1);
`ifdef GECKO_XOR_COUNT_EN
    check("t7_bytes", bytes, out_total);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
